// File: rtl/ahb_apb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-Lite bridge slave between NUM_REQ single-transfer requesters.
// Latency: request seen at edge k -> address phase cycle k+1, DONE pulse cycle k+3 with no wait states.
// Backpressure: H_READY_OUT low stalls the address or data phase indefinitely; requests wait in IDLE.
module ahb_apb_bridge_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TRAN_WIDTH = 3
) (
    input  logic                          H_CLK,
    input  logic                          H_RESET_n,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            REQ_WRITE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_WDATA,
    output logic [NUM_REQ-1:0]            GNT,
    output logic [NUM_REQ-1:0]            DONE,
    output logic [DATA_WIDTH-1:0]         RDATA,
    output logic                          ERR,
    output logic                          H_SEL_APB,
    output logic [TRAN_WIDTH-1:0]         H_TRANS,
    output logic                          H_WRITE,
    output logic [ADDR_WIDTH-1:0]         H_ADDR,
    output logic [DATA_WIDTH-1:0]         H_WDATA,
    output logic                          H_READY_IN,
    input  logic                          H_READY_OUT,
    input  logic                          H_RESP,
    input  logic [DATA_WIDTH-1:0]         H_RDATA
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TRAN_WIDTH-1:0] TR_IDLE   = '0;
    localparam logic [TRAN_WIDTH-1:0] TR_NONSEQ = TRAN_WIDTH'(2);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       last_q;
    logic                   wr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;

    int                     cand;
    logic [IDX_W-1:0]       cand_idx;
    logic                   pick_vld;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_REQ-1:0]     pick_oh;
    logic                   pick_wr;
    logic [ADDR_WIDTH-1:0]  pick_addr;
    logic [DATA_WIDTH-1:0]  pick_wdata;

    // Single-slave system: the bridge's own ready is the bus HREADY.
    assign H_READY_IN = H_READY_OUT;

    // Walk downward so the closest requester after last_q is the one that sticks.
    always_comb begin
        cand     = 0;
        cand_idx = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand     = (int'(last_q) + i) % NUM_REQ;
            cand_idx = cand[IDX_W-1:0];
            if (REQ[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin
        pick_oh    = '0;
        pick_wr    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_oh[i] = 1'b1;
                pick_wr    = REQ_WRITE[i];
                pick_addr  = REQ_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                pick_wdata = REQ_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge H_CLK or negedge H_RESET_n) begin
        if (!H_RESET_n) begin
            state     <= S_IDLE;
            last_q    <= IDX_W'(NUM_REQ - 1);
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            GNT       <= '0;
            DONE      <= '0;
            RDATA     <= '0;
            ERR       <= 1'b0;
            H_SEL_APB <= 1'b0;
            H_TRANS   <= TR_IDLE;
            H_WRITE   <= 1'b0;
            H_ADDR    <= '0;
            H_WDATA   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        last_q    <= pick_idx;
                        wr_q      <= pick_wr;
                        wdata_q   <= pick_wdata;
                        GNT       <= pick_oh;
                        H_SEL_APB <= 1'b1;
                        H_TRANS   <= TR_NONSEQ;
                        H_WRITE   <= pick_wr;
                        H_ADDR    <= pick_addr;
                        state     <= S_ADDR;
                    end else begin
                        H_SEL_APB <= 1'b0;
                        H_TRANS   <= TR_IDLE;
                        H_WRITE   <= 1'b0;
                        H_ADDR    <= '0;
                        H_WDATA   <= '0;
                    end
                end
                S_ADDR: begin
                    if (H_READY_OUT) begin
                        H_SEL_APB <= 1'b0;
                        H_TRANS   <= TR_IDLE;
                        H_WDATA   <= wr_q ? wdata_q : '0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (H_READY_OUT) begin
                        if (!wr_q) begin
                            RDATA <= H_RDATA;
                        end
                        ERR     <= H_RESP;
                        DONE    <= GNT;
                        H_WDATA <= '0;
                        state   <= S_RESP;
                    end
                end
                default: begin
                    DONE    <= '0;
                    GNT     <= '0;
                    H_WRITE <= 1'b0;
                    H_ADDR  <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_apb_bridge_arbiter.sv
// Directed bench for the bridge arbiter: the bridge side is driven directly from the stimulus.
module tb_ahb_apb_bridge_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TW = 3;

    logic              H_CLK = 1'b0;
    logic              H_RESET_n;
    logic [NR-1:0]     REQ;
    logic [NR-1:0]     REQ_WRITE;
    logic [NR*AW-1:0]  REQ_ADDR;
    logic [NR*DW-1:0]  REQ_WDATA;
    logic [NR-1:0]     GNT;
    logic [NR-1:0]     DONE;
    logic [DW-1:0]     RDATA;
    logic              ERR;
    logic              H_SEL_APB;
    logic [TW-1:0]     H_TRANS;
    logic              H_WRITE;
    logic [AW-1:0]     H_ADDR;
    logic [DW-1:0]     H_WDATA;
    logic              H_READY_IN;
    logic              H_READY_OUT;
    logic              H_RESP;
    logic [DW-1:0]     H_RDATA;

    int tests = 0;
    int fails = 0;

    always #5 H_CLK = ~H_CLK;

    ahb_apb_bridge_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRAN_WIDTH(TW)
    ) dut (
        .H_CLK(H_CLK), .H_RESET_n(H_RESET_n),
        .REQ(REQ), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .ERR(ERR),
        .H_SEL_APB(H_SEL_APB), .H_TRANS(H_TRANS), .H_WRITE(H_WRITE), .H_ADDR(H_ADDR),
        .H_WDATA(H_WDATA), .H_READY_IN(H_READY_IN), .H_READY_OUT(H_READY_OUT),
        .H_RESP(H_RESP), .H_RDATA(H_RDATA)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle forward, sampled on the falling edge, with the structural invariants checked.
    task automatic tick();
        @(negedge H_CLK);
        chk("gnt_onehot0", {63'd0, $onehot0(GNT)}, 64'd1);
        chk("done_in_gnt", {60'd0, DONE & ~GNT}, 64'd0);
    endtask

    task automatic post(input int idx, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata);
        REQ_WRITE[idx]          = wr;
        REQ_ADDR[idx*AW +: AW]  = addr;
        REQ_WDATA[idx*DW +: DW] = wdata;
        REQ[idx]                = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge H_CLK);
        H_RESET_n = 1'b0;
        #2;
        H_RESET_n = 1'b1;
    endtask

    initial begin
        H_RESET_n   = 1'b0;
        REQ         = '0;
        REQ_WRITE   = '0;
        REQ_ADDR    = '0;
        REQ_WDATA   = '0;
        H_READY_OUT = 1'b1;
        H_RESP      = 1'b0;
        H_RDATA     = '0;

        // Reset values
        tick();
        chk("rst_gnt", GNT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_sel", H_SEL_APB, 0);
        chk("rst_trans", H_TRANS, 0);
        chk("rst_addr", H_ADDR, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_ready_in_hi", H_READY_IN, 1);
        H_READY_OUT = 1'b0;
        #1;
        chk("rst_ready_in_lo", H_READY_IN, 0);
        H_READY_OUT = 1'b1;
        H_RESET_n = 1'b1;

        // Write from requester 0, zero wait states
        post(0, 1'b1, 32'hA0F, 32'hDEADBEEF);
        tick();
        chk("w0_sel", H_SEL_APB, 1);
        chk("w0_trans", H_TRANS, 2);
        chk("w0_addr", H_ADDR, 32'hA0F);
        chk("w0_write", H_WRITE, 1);
        chk("w0_gnt", GNT, 4'b0001);
        tick();
        chk("w0_data_sel", H_SEL_APB, 0);
        chk("w0_data_trans", H_TRANS, 0);
        chk("w0_wdata", H_WDATA, 32'hDEADBEEF);
        chk("w0_done_early", DONE, 0);
        tick();
        chk("w0_done", DONE, 4'b0001);
        chk("w0_err", ERR, 0);
        chk("w0_wdata_clr", H_WDATA, 0);
        REQ = '0;
        tick();
        chk("w0_gnt_drop", GNT, 0);
        chk("w0_done_drop", DONE, 0);

        // Read from requester 2
        H_RDATA = 32'h12345678;
        post(2, 1'b0, 32'h32, 32'h0);
        tick();
        chk("r2_gnt_a", GNT, 4'b0100);
        chk("r2_addr", H_ADDR, 32'h32);
        chk("r2_write", H_WRITE, 0);
        tick();
        chk("r2_gnt_d", GNT, 4'b0100);
        chk("r2_wdata_zero", H_WDATA, 0);
        tick();
        chk("r2_done", DONE, 4'b0100);
        chk("r2_rdata", RDATA, 32'h12345678);
        chk("r2_gnt_r", GNT, 4'b0100);
        REQ = '0;
        tick();
        chk("r2_gnt_drop", GNT, 0);

        // All four requesting: round-robin order from a fresh pointer
        pulse_reset();
        for (int i = 0; i < NR; i++) post(i, 1'b0, AW'(32'h100 + i), 32'h0);
        for (int n = 0; n < 5; n++) begin
            logic [NR-1:0] oh;
            oh = NR'(1) << (n % NR);
            tick();
            chk("rr_gnt", GNT, oh);
            chk("rr_sel", H_SEL_APB, 1);
            chk("rr_addr", H_ADDR, 32'h100 + (n % NR));
            tick();
            chk("rr_done_dphase", DONE, 0);
            tick();
            chk("rr_done", DONE, oh);
            if (n == 4) REQ = '0;
            tick();
            chk("rr_done_one_cycle", DONE, 0);
            chk("rr_gnt_idle", GNT, 0);
        end

        // Stalls: 3 wait cycles in address phase, 2 in data phase (requester 3 after pointer at 0)
        H_RDATA     = 32'hCAFEF00D;
        H_READY_OUT = 1'b0;
        post(3, 1'b0, 32'h44, 32'h0);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c <= 4) begin
                chk("stall_trans", H_TRANS, 2);
                chk("stall_addr", H_ADDR, 32'h44);
            end
            chk("stall_done", DONE, (c == 8) ? 4'b1000 : 4'b0000);
            chk("stall_gnt", GNT, 4'b1000);
            H_READY_OUT = (c == 4 || c >= 7);
        end
        chk("stall_rdata", RDATA, 32'hCAFEF00D);
        REQ = '0;
        tick();
        chk("stall_gnt_drop", GNT, 0);

        // Error response on a read, then a clean write that leaves RDATA alone
        H_RESP  = 1'b1;
        H_RDATA = 32'h0BADBAD0;
        post(1, 1'b0, 32'h10, 32'h0);
        tick();
        chk("err_gnt", GNT, 4'b0010);
        tick();
        tick();
        chk("err_done", DONE, 4'b0010);
        chk("err_flag", ERR, 1);
        chk("err_rdata", RDATA, 32'h0BADBAD0);
        REQ    = '0;
        H_RESP = 1'b0;
        tick();
        post(0, 1'b1, 32'h20, 32'h55);
        tick();
        chk("ok_gnt", GNT, 4'b0001);
        tick();
        chk("ok_wdata", H_WDATA, 32'h55);
        tick();
        chk("ok_done", DONE, 4'b0001);
        chk("ok_err", ERR, 0);
        chk("ok_rdata_kept", RDATA, 32'h0BADBAD0);
        REQ = '0;
        tick();

        // Reset during the data phase of a write
        post(2, 1'b1, 32'h30, 32'h77);
        tick();
        chk("ar_gnt", GNT, 4'b0100);
        tick();
        chk("ar_wdata", H_WDATA, 32'h77);
        H_RESET_n = 1'b0;
        #1;
        chk("ar_gnt_clr", GNT, 0);
        chk("ar_sel_clr", H_SEL_APB, 0);
        chk("ar_wdata_clr", H_WDATA, 0);
        REQ = '0;
        post(1, 1'b0, 32'h14, 32'h0);
        tick();
        chk("ar_no_done", DONE, 0);
        H_RESET_n = 1'b1;
        tick();
        chk("ar_regrant", GNT, 4'b0010);
        chk("ar_regrant_addr", H_ADDR, 32'h14);
        tick();
        tick();
        chk("ar_regrant_done", DONE, 4'b0010);
        REQ = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
